// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one shift-add multiplier among NREQ requesters.
// Issues init, waits for done (with watchdog), returns the product, then drains the held done.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [2*W-1:0]    res_out,
  output logic [NREQ-1:0]   res_valid,
  output logic              err,
  output logic              busy,
  output logic [W-1:0]      mult_a,
  output logic [W-1:0]      mult_b,
  output logic              mult_init,
  output logic              mult_rst,
  input  logic              mult_done,
  input  logic [2*W-1:0]    mult_pp
);

  localparam int IW  = $clog2(NREQ);
  localparam int IW1 = IW + 1;
  localparam int TW  = 16;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESULT, ABORT, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] pick;
  logic [IW-1:0] sel_nxt;
  logic [IW:0]   cand;
  logic [TW-1:0] timer;

  // First asserted request at or after ptr; scanning downward lets the nearest one win.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + IW1'(k);
      if (cand >= IW1'(NREQ)) cand = cand - IW1'(NREQ);
      if (req[cand[IW-1:0]]) pick = cand[IW-1:0];
    end
  end

  assign sel_nxt = (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      timer     <= '0;
      gnt       <= '0;
      res_out   <= '0;
      res_valid <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      mult_init <= 1'b0;
      mult_rst  <= 1'b1;
    end else begin
      mult_init <= 1'b0;
      mult_rst  <= 1'b0;
      err       <= 1'b0;
      res_valid <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel       <= pick;
            gnt       <= NREQ'(1) << pick;
            mult_a    <= a_in[pick*W +: W];
            mult_b    <= b_in[pick*W +: W];
            mult_init <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mult_done) begin
            res_out   <= mult_pp;
            res_valid <= gnt;
            state     <= RESULT;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err      <= 1'b1;
            mult_rst <= 1'b1;
            state    <= ABORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESULT: begin
          gnt   <= '0;
          ptr   <= sel_nxt;
          state <= DRAIN;
        end
        ABORT: begin
          gnt   <= '0;
          ptr   <= sel_nxt;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DRAIN: begin
          // Done is a level held for several cycles; wait it out so it is not seen as the next completion.
          if (!mult_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: multiplier model, scoreboard queue, vector table
// and hand-written sequences for fairness, wrap, watchdog, stale done and mid-op reset.
module tb_mult_share_arb;
  localparam int NREQ = 4, W = 16, TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt, res_valid;
  logic [2*W-1:0]    res_out, mult_pp;
  logic              err, busy, mult_init, mult_rst;
  logic [W-1:0]      mult_a, mult_b;
  logic              mult_done = 1'b0;

  mult_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .res_out(res_out), .res_valid(res_valid), .err(err), .busy(busy),
    .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init), .mult_rst(mult_rst),
    .mult_done(mult_done), .mult_pp(mult_pp)
  );

  always #5 clk = ~clk;

  // Multiplier model: done rises mdly cycles after init and is held for mhold cycles.
  int          mdly = 20, mhold = 10, cnt = 0, hcnt = 0;
  bit          mnever = 1'b0;
  logic [1:0]  phase = 2'd0;
  logic [31:0] prod = '0;

  always @(posedge clk) begin
    if (mult_rst) begin
      phase     <= 2'd0;
      mult_done <= 1'b0;
    end else if (mult_init) begin
      prod  <= {16'b0, mult_a} * {16'b0, mult_b};
      cnt   <= mdly;
      phase <= mnever ? 2'd0 : 2'd1;
    end else if (phase == 2'd1) begin
      if (cnt <= 1) begin mult_done <= 1'b1; hcnt <= mhold; phase <= 2'd2; end
      else cnt <= cnt - 1;
    end else if (phase == 2'd2) begin
      if (hcnt <= 1) begin mult_done <= 1'b0; phase <= 2'd0; end
      else hcnt <= hcnt - 1;
    end
  end
  assign mult_pp = mult_done ? prod : 32'hDEAD_BEEF;

  typedef struct { logic [NREQ-1:0] vld; logic [2*W-1:0] prod; } exp_t;
  typedef struct { logic [NREQ-1:0] rq; logic [W-1:0] a, b; logic [NREQ-1:0] vld; logic [2*W-1:0] prod; int lat; } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[4];
  logic [W-1:0] av[NREQ], bv[NREQ];
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*W +: W] = av[i];
      b_in[i*W +: W] = bv[i];
    end
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.vld = '0;
    e.vld[idx] = 1'b1;
    e.prod = {16'b0, av[idx]} * {16'b0, bv[idx]};
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: unexpected res_valid=%0h res_out=%0h", name, res_valid, res_out);
    end else begin
      e = sbq.pop_front();
      chk({name, "_vld"}, 64'(res_valid), 64'(e.vld));
      chk({name, "_res"}, 64'(res_out), 64'(e.prod));
    end
  endtask

  task automatic get_result(input string name, input int bound);
    bit got = 1'b0;
    for (int c = 1; c <= bound && !got; c++) begin
      @(negedge clk);
      if (res_valid != 0) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no res_valid within %0d cycles", name, bound);
    end else begin
      sb_check(name);
      @(negedge clk);
      chk({name, "_pulse"}, 64'(res_valid), 64'd0);
    end
  endtask

  task automatic wait_idle(input string name, input int bound, output int n);
    n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s: busy still high after %0d cycles", name, bound);
    end
  endtask

  initial begin
    int n, gc, ic, rc, ec, mrc, nerr, nrv, idx, init2, ninit, nres, dfall;
    logic [NREQ-1:0] gseen;
    logic prev_done;

    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    for (int i = 0; i < NREQ; i++) begin av[i] = '0; bv[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_res_out", 64'(res_out), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mult_ab", 64'({mult_a, mult_b}), 64'd0);
    chk("rst_mult_init", 64'(mult_init), 64'd0);
    chk("rst_mult_rst", 64'(mult_rst), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mult_rst_drop", 64'(mult_rst), 64'd0);

    // Fairness: all four held, order 0,1,2,3,0.
    mdly = 4; mhold = 3;
    av[0] = 16'd11; av[1] = 16'd22; av[2] = 16'd33; av[3] = 16'd44;
    bv[0] = 16'd3;  bv[1] = 16'd5;  bv[2] = 16'd7;  bv[3] = 16'd9;
    drive_ops();
    push(0); push(1); push(2); push(3); push(0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) get_result("fair", 100);
    req = '0;
    wait_idle("fair_idle", 50, n);

    // Vector table: single requests, req dropped at grant, operands trashed after grant.
    tbl[0] = '{4'b0001, 16'd300,  16'd7,    4'b0001, 32'd2100,      23};
    tbl[1] = '{4'b0100, 16'hFFFF, 16'hFFFF, 4'b0100, 32'hFFFE0001,  23};
    tbl[2] = '{4'b1000, 16'd0,    16'd1234, 4'b1000, 32'd0,         23};
    tbl[3] = '{4'b0010, 16'd1000, 16'd1000, 4'b0010, 32'd1000000,   23};
    mdly = 20; mhold = 10;
    for (int t = 0; t < 4; t++) begin
      exp_t e;
      a_in = {NREQ{16'hAAAA}}; b_in = {NREQ{16'h5555}};
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (tbl[t].rq[i]) idx = i;
      a_in[idx*W +: W] = tbl[t].a;
      b_in[idx*W +: W] = tbl[t].b;
      e.vld = tbl[t].vld; e.prod = tbl[t].prod;
      sbq.push_back(e);
      req = tbl[t].rq;
      gc = -1; ic = -1; rc = -1; gseen = '0;
      for (int c = 1; c <= 60 && rc < 0; c++) begin
        @(negedge clk);
        if (gc < 0 && gnt != 0) begin gc = c; gseen = gnt; req = '0; a_in = '1; b_in = '1; end
        if (ic < 0 && mult_init) ic = c;
        if (res_valid != 0) begin rc = c; sb_check("vec"); end
      end
      chk("vec_gnt", 64'(gseen), 64'(tbl[t].vld));
      chk("vec_grant_lat", 64'(gc), 64'd1);
      chk("vec_init_lat", 64'(ic), 64'd1);
      chk("vec_res_lat", 64'(rc), 64'(tbl[t].lat));
      @(negedge clk);
      chk("vec_pulse", 64'(res_valid), 64'd0);
      wait_idle("vec_idle", 50, n);
      chk("vec_busy_gap", 64'(n + 1), 64'(mhold));
      chk("vec_done_low", 64'(mult_done), 64'd0);
    end

    // Wrap and skip: move ptr to 3, then req=0101 gives 0 then 2.
    mdly = 4; mhold = 3;
    av[0] = 16'd123; bv[0] = 16'd456; av[2] = 16'd789; bv[2] = 16'd321;
    drive_ops();
    push(2);
    req = 4'b0100;
    get_result("ptr3", 60);
    req = '0;
    wait_idle("ptr3_idle", 50, n);
    push(0); push(2);
    req = 4'b0101;
    get_result("wrap0", 60);
    get_result("wrap2", 60);
    req = '0;
    wait_idle("wrap_idle", 50, n);

    // Watchdog on requester 1: err/mult_rst in the cycle after the 255th WAIT cycle.
    mnever = 1'b1;
    req = 4'b0010;
    gc = -1; ec = -1; mrc = -1; nerr = 0; nrv = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (gc < 0 && gnt != 0) begin gc = c; chk("wd_gnt", 64'(gnt), 64'h2); req = '0; end
      if (err) begin nerr++; if (ec < 0) ec = c; end
      if (mult_rst && mrc < 0) mrc = c;
      if (res_valid != 0) nrv++;
      if (ec > 0 && c == ec + 1) begin
        chk("wd_gnt_clr", 64'(gnt), 64'd0);
        chk("wd_busy_clr", 64'(busy), 64'd0);
      end
    end
    chk("wd_err_cycle", 64'(ec), 64'd257);
    chk("wd_mrst_cycle", 64'(mrc), 64'd257);
    chk("wd_err_width", 64'(nerr), 64'd1);
    chk("wd_no_valid", 64'(nrv), 64'd0);
    mnever = 1'b0;
    push(2);
    req = 4'b0110;
    get_result("wd_next", 60);
    req = '0;
    wait_idle("wd_idle", 50, n);

    // Stale done: req re-raised during RESULT while done is still held.
    mdly = 3; mhold = 10;
    av[0] = 16'd250; bv[0] = 16'd40;
    drive_ops();
    push(0);
    req = 4'b0001;
    ninit = 0; init2 = -1; nres = 0; dfall = -1; prev_done = 1'b0;
    for (int c = 1; c <= 60 && nres < 2; c++) begin
      @(negedge clk);
      if (mult_init) begin
        ninit++;
        if (ninit == 1) begin req = '0; av[0] = 16'd777; bv[0] = 16'd99; drive_ops(); push(0); end
        if (ninit == 2) begin init2 = c; req = '0; end
      end
      if (prev_done && !mult_done && dfall < 0) dfall = c;
      prev_done = mult_done;
      if (res_valid != 0) begin nres++; sb_check("stale"); if (nres == 1) req = 4'b0001; end
    end
    chk("stale_nres", 64'(nres), 64'd2);
    chk("stale_done_fall", 64'(dfall), 64'd15);
    chk("stale_init2", 64'(init2), 64'd17);
    wait_idle("stale_idle", 50, n);

    // Reset during WAIT: no result, no err, ptr back to 0.
    mdly = 20; mhold = 3;
    av[0] = 16'd5; bv[0] = 16'd6; av[1] = 16'd8; bv[1] = 16'd9;
    drive_ops();
    req = 4'b0001;
    repeat (2) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mrst", 64'(mult_rst), 64'd1);
    rst = 1'b0;
    nrv = 0; nerr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid != 0) nrv++;
      if (err) nerr++;
    end
    chk("mid_rst_no_valid", 64'(nrv), 64'd0);
    chk("mid_rst_no_err", 64'(nerr), 64'd0);
    push(0);
    req = 4'b0011;
    get_result("mid_rst_ptr0", 60);
    req = '0;
    wait_idle("mid_rst_idle", 50, n);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
